// File: rtl/galaksija_kbd_pkg.sv
// Galaksija keyboard matrix definitions shared by the PS/2 and serial key paths.
package galaksija_kbd_pkg;

  // Matrix positions with a fixed meaning
  localparam logic [5:0] KEY_SHIFT = 6'd53;
  localparam logic [5:0] KEY_CR    = 6'd48;
  localparam logic [5:0] KEY_SPACE = 6'd31;

  // Result of translating one ASCII byte into a matrix press
  typedef struct packed {
    logic       valid;
    logic       shift;
    logic [5:0] idx;
  } key_code_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {K_IDLE, K_PRESS, K_GAP} key_state_t;

  // ASCII -> matrix position; shifted punctuation sits on the digit/symbol keys
  function automatic key_code_t ascii_to_key(input logic [7:0] ch);
    key_code_t k;
    k = '0;
    if ((ch >= 8'h41 && ch <= 8'h5A) || (ch >= 8'h61 && ch <= 8'h7A)) begin
      k.valid = 1'b1;
      k.idx   = {1'b0, ch[4:0]};
    end else if (ch >= 8'h30 && ch <= 8'h39) begin
      k.valid = 1'b1;
      k.idx   = {2'b10, ch[3:0]};
    end else begin
      k.valid = 1'b1;
      case (ch)
        8'h0D: k.idx = KEY_CR;
        8'h20: k.idx = KEY_SPACE;
        8'h3B: k.idx = 6'd42;   // ;
        8'h3A: k.idx = 6'd43;   // :
        8'h2C: k.idx = 6'd44;   // ,
        8'h3D: k.idx = 6'd45;   // =
        8'h2E: k.idx = 6'd46;   // .
        8'h2F: k.idx = 6'd47;   // /
        8'h21: begin k.shift = 1'b1; k.idx = 6'd33; end  // ! = SHIFT+1
        8'h22: begin k.shift = 1'b1; k.idx = 6'd34; end  // "
        8'h23: begin k.shift = 1'b1; k.idx = 6'd35; end  // #
        8'h24: begin k.shift = 1'b1; k.idx = 6'd36; end  // $
        8'h25: begin k.shift = 1'b1; k.idx = 6'd37; end  // %
        8'h26: begin k.shift = 1'b1; k.idx = 6'd38; end  // &
        8'h27: begin k.shift = 1'b1; k.idx = 6'd39; end  // '
        8'h28: begin k.shift = 1'b1; k.idx = 6'd40; end  // (
        8'h29: begin k.shift = 1'b1; k.idx = 6'd41; end  // )
        8'h2B: begin k.shift = 1'b1; k.idx = 6'd42; end  // + = SHIFT+;
        8'h2A: begin k.shift = 1'b1; k.idx = 6'd43; end  // * = SHIFT+:
        8'h3C: begin k.shift = 1'b1; k.idx = 6'd44; end  // <
        8'h2D: begin k.shift = 1'b1; k.idx = 6'd45; end  // -
        8'h3E: begin k.shift = 1'b1; k.idx = 6'd46; end  // >
        8'h3F: begin k.shift = 1'b1; k.idx = 6'd47; end  // ?
        default: k.valid = 1'b0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-cycle result pulses.
module uart_rx_8n1
  import galaksija_kbd_pkg::*;
#(
  parameter int F_CLK = 25000000,
  parameter int BAUD  = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int BIT_CYC  = F_CLK / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC + 1);

  logic             r_meta, r_sync, r_prev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid, r_frame_err;

  // Synchronise the line, then walk start/data/stop sampling at bit centres
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta      <= 1'b1;
      r_sync      <= 1'b1;
      r_prev      <= 1'b1;
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_meta      <= rx;
      r_sync      <= r_meta;
      r_prev      <= r_sync;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_prev && !r_sync) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == CNT_W'(HALF_CYC - 1)) begin
            r_cnt <= '0;
            r_bit <= '0;
            // A line that is high again at mid-start was only a glitch
            r_state <= r_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == CNT_W'(BIT_CYC - 1)) begin
            r_cnt   <= '0;
            r_shift <= {r_sync, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else r_bit <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == CNT_W'(BIT_CYC - 1)) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;

endmodule

// File: rtl/serial_key_injector.sv
// Serial-to-keyboard bridge: UART bytes are buffered and replayed as timed
// key presses on the Galaksija matrix.
module serial_key_injector
  import galaksija_kbd_pkg::*;
#(
  parameter int F_CLK      = 25000000,
  parameter int BAUD       = 115200,
  parameter int HOLD_MS    = 40,
  parameter int GAP_MS     = 40,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic [5:0] addr,
  output logic       key_n,
  output logic       busy,
  output logic       overrun,
  output logic       frame_err
);

  localparam int HOLD_CYC = F_CLK / 1000 * HOLD_MS;
  localparam int GAP_CYC  = F_CLK / 1000 * GAP_MS;
  localparam int TMR_MAX  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  logic [7:0] w_rx_data;
  logic       w_rx_valid, w_rx_frame_err;

  uart_rx_8n1 #(.F_CLK(F_CLK), .BAUD(BAUD)) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (w_rx_data),
    .valid     (w_rx_valid),
    .frame_err (w_rx_frame_err)
  );

  logic [7:0]       r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overrun;
  key_state_t       r_kstate;
  key_code_t        r_key;
  logic [TMR_W-1:0] r_timer;

  logic      w_empty, w_full, w_pop, w_push;
  key_code_t w_head_key;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_head_key = ascii_to_key(r_fifo_mem[r_rd_ptr]);
  assign w_pop      = (r_kstate == K_IDLE) && !w_empty;
  // A simultaneous pop frees a slot, so a full FIFO still takes the byte
  assign w_push     = w_rx_valid && (!w_full || w_pop);

  // Byte storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_rx_data;
  end

  // FIFO pointers, occupancy and the dropped-byte pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_rx_valid && !w_push;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Key FSM: pop a byte, hold its key for HOLD_CYC, then release for GAP_CYC
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_kstate <= K_IDLE;
      r_key    <= '0;
      r_timer  <= '0;
    end else begin
      case (r_kstate)
        K_IDLE: begin
          // Unmapped bytes are popped and skipped without a press
          if (!w_empty && w_head_key.valid) begin
            r_key    <= w_head_key;
            r_timer  <= TMR_W'(HOLD_CYC - 1);
            r_kstate <= K_PRESS;
          end
        end
        K_PRESS: begin
          if (r_timer == '0) begin
            r_timer  <= TMR_W'(GAP_CYC - 1);
            r_kstate <= K_GAP;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        K_GAP: begin
          if (r_timer == '0) r_kstate <= K_IDLE;
          else r_timer <= r_timer - TMR_W'(1);
        end
        default: r_kstate <= K_IDLE;
      endcase
    end
  end

  // Combinational so a CPU read of the matrix sees the key in the same cycle
  assign key_n = !((r_kstate == K_PRESS) &&
                   ((addr == r_key.idx) || (r_key.shift && addr == KEY_SHIFT)));

  assign busy      = !w_empty || (r_kstate != K_IDLE);
  assign overrun   = r_overrun;
  assign frame_err = w_rx_frame_err;

endmodule

// File: tb/tb_serial_key_injector.sv
// Directed bench for serial_key_injector with shortened timing parameters.
`timescale 1ns/1ps
module tb_serial_key_injector;

  localparam int BIT_CYC  = 10;    // 100 kHz / 10 kBd
  localparam int HOLD_CYC = 1200;  // 100 kHz / 1000 * 12 ms
  localparam int GAP_CYC  = 500;   // 100 kHz / 1000 * 5 ms

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [5:0] addr = 6'd0;
  logic       key_n, busy, overrun, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_ovr = 0;
  int n_fe = 0;
  int n_busy = 0;

  logic [7:0] burst [10] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                             8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B};

  always #5 clk = ~clk;

  serial_key_injector #(
    .F_CLK(100000), .BAUD(10000), .HOLD_MS(12), .GAP_MS(5), .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .addr      (addr),
    .key_n     (key_n),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (overrun)   n_ovr++;
    if (frame_err) n_fe++;
    if (busy)      n_busy++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Read all 64 matrix positions within the current clock low phase
  task automatic scan_keys(output logic [63:0] mask);
    logic [5:0] saved;
    saved = addr;
    mask = '0;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #0.02;
      mask[a] = ~key_n;
    end
    addr = saved;
    #0.02;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_key(input logic [5:0] a, input int limit, output logic ok);
    int n;
    n = 0;
    ok = 1'b0;
    addr = a;
    #0.02;
    while (n < limit) begin
      if (key_n == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [63:0] mask;
    logic        ok;
    int          c, fe0, ovr0, b0;

    // Reset state
    repeat (3) @(negedge clk);
    scan_keys(mask);
    check("reset_keys", mask, 64'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 'A' -> addr 1 held for HOLD_CYC, then GAP_CYC released
    fork send_byte(8'h41, 1'b1); join_none
    wait_key(6'd1, 200, ok);
    check("t1_press_seen", ok, 1'b1);
    scan_keys(mask);
    check("t1_press_mask", mask, 64'd1 << 1);
    c = 0;
    while (key_n == 1'b0 && c < 5000) begin
      c++;
      @(negedge clk);
    end
    check("t1_hold_cycles", c, HOLD_CYC);
    scan_keys(mask);
    check("t1_gap_mask", mask, 64'd0);
    check("t1_gap_busy", busy, 1'b1);
    c = 0;
    while (busy && c < 5000) begin
      c++;
      @(negedge clk);
    end
    check("t1_gap_cycles", c, GAP_CYC);
    check("t1_idle_busy", busy, 1'b0);

    // 2: '!' -> SHIFT (53) plus key 33
    fork send_byte(8'h21, 1'b1); join_none
    wait_key(6'd33, 200, ok);
    check("t2_press_seen", ok, 1'b1);
    scan_keys(mask);
    check("t2_press_mask", mask, (64'd1 << 33) | (64'd1 << 53));
    wait_idle(3000);
    check("t2_idle_busy", busy, 1'b0);

    // 3: 'X' then 10 bytes during its press -> 8 buffered, 2 dropped
    ovr0 = n_ovr;
    fork
      begin
        send_byte(8'h58, 1'b1);
        for (int i = 0; i < 10; i++) send_byte(burst[i], 1'b1);
      end
    join_none
    wait_key(6'd24, 200, ok);
    check("t3_press_X", ok, 1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_key(6'(2 + i), 2000, ok);
      check($sformatf("t3_press_seen_%0d", i), ok, 1'b1);
      scan_keys(mask);
      check($sformatf("t3_press_mask_%0d", i), mask, 64'd1 << (2 + i));
    end
    wait_idle(2500);
    check("t3_idle_busy", busy, 1'b0);
    check("t3_overrun_pulses", n_ovr - ovr0, 2);

    // 4: 0x55 with low stop bit, then a short glitch
    fe0 = n_fe;
    b0 = n_busy;
    send_byte(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    check("t4_frame_err_pulses", n_fe - fe0, 1);
    check("t4_no_push_busy", n_busy - b0, 0);
    scan_keys(mask);
    check("t4_keys", mask, 64'd0);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("t4_glitch_frame_err", n_fe - fe0, 1);
    check("t4_glitch_busy", n_busy - b0, 0);

    // 5: unmapped 0x07 skipped, then 'a' pressed one cycle after its pop
    b0 = n_busy;
    send_byte(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    check("t5_unmapped_busy_cycles", n_busy - b0, 1);
    scan_keys(mask);
    check("t5_unmapped_keys", mask, 64'd0);
    addr = 6'd1;
    fork send_byte(8'h61, 1'b1); join_none
    c = 0;
    while (!busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("t5_busy_rise", busy, 1'b1);
    check("t5_key_before_pop", key_n, 1'b1);
    @(negedge clk);
    check("t5_key_after_pop", key_n, 1'b0);
    wait_idle(2000);
    check("t5_idle_busy", busy, 1'b0);

    // 6: reset mid-press and mid-byte, then a clean byte
    fork send_byte(8'h5A, 1'b1); join_none
    wait_key(6'd26, 200, ok);
    check("t6_press_seen", ok, 1'b1);
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t6_rst_key", key_n, 1'b1);
    check("t6_rst_busy", busy, 1'b0);
    scan_keys(mask);
    check("t6_rst_keys", mask, 64'd0);
    fe0 = n_fe;
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    b0 = n_busy;
    repeat (200) @(negedge clk);
    check("t6_midbyte_busy", n_busy - b0, 0);
    check("t6_midbyte_frame_err", n_fe - fe0, 0);
    addr = 6'd3;
    fork send_byte(8'h43, 1'b1); join_none
    wait_key(6'd3, 200, ok);
    check("t6_clean_press", ok, 1'b1);
    scan_keys(mask);
    check("t6_clean_mask", mask, 64'd1 << 3);
    wait_idle(2000);
    check("t6_idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
